// File: rtl/mult_accumulator.sv
// Frame accumulator behind the array multiplier: sums CNT products per frame.
// Optional saturating adds enabled by defining SATURATE_EN.
module mult_accumulator #(
  parameter int N   = 4,
  parameter int M   = 4,
  parameter int CNT = 4,
  parameter int AW  = N + M + 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            k,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N+M-1:0]  prod,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   acc_out,
  output logic            ovf
);
  // state | meaning
  // IDLE  | waiting for the first beat of a frame
  // ACCUM | summing beats 2..CNT
  // HOLD  | frame total presented, input blocked until taken

  localparam int PW = N + M;
  localparam int CW = $clog2(CNT + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            k_lat_q, k_lat_d;
  logic            beat;
  logic [AW-1:0]   ext_val;
  logic [AW-1:0]   sum;

  function automatic logic [AW-1:0] ext(input logic [PW-1:0] p, input logic s);
    ext = s ? AW'($signed(p)) : AW'(p);
  endfunction

  assign in_ready  = (state_q != HOLD) && !clr;
  assign beat      = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign acc_out   = acc_q;
  assign ext_val   = ext(prod, k_lat_q);

`ifdef SATURATE_EN
  logic            ovf_q, ovf_d;
  logic [AW:0]     sum_full;
  logic            add_ovf;
  logic [AW-1:0]   sat_val;

  assign sum_full = {1'b0, acc_q} + {1'b0, ext_val};
  assign sum      = sum_full[AW-1:0];
  // Signed overflow: operands agree in sign but the result does not.
  assign add_ovf  = k_lat_q ? ((acc_q[AW-1] == ext_val[AW-1]) && (sum[AW-1] != acc_q[AW-1]))
                            : sum_full[AW];
  assign sat_val  = !k_lat_q      ? {AW{1'b1}} :
                    ext_val[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  assign ovf      = ovf_q;
`else
  assign sum = acc_q + ext_val;
  assign ovf = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    k_lat_d = k_lat_q;
`ifdef SATURATE_EN
    ovf_d   = ovf_q;
`endif
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
`ifdef SATURATE_EN
      ovf_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (beat) begin
          k_lat_d = k;
          acc_d   = ext(prod, k);
          if (CNT == 1) begin
            state_d = HOLD;
            count_d = '0;
          end else begin
            state_d = ACCUM;
            count_d = CW'(1);
          end
        end
        ACCUM: if (beat) begin
`ifdef SATURATE_EN
          if (!ovf_q) begin
            if (add_ovf) begin
              acc_d = sat_val;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum;
            end
          end
`else
          acc_d = sum;
`endif
          if (count_q == CW'(CNT - 1)) begin
            state_d = HOLD;
            count_d = '0;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        HOLD: if (out_ready) begin
          state_d = IDLE;
`ifdef SATURATE_EN
          ovf_d   = 1'b0;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      k_lat_q <= 1'b0;
`ifdef SATURATE_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      k_lat_q <= k_lat_d;
`ifdef SATURATE_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule
